// File: rtl/linked_list_pkg.sv
// Shared types and widths for the linked-list hash table.
// Free-pointer pool state lives here with the table address width.
package linked_list_pkg;

   localparam int TABLE_ADDR_WIDTH = 4;

   typedef enum logic {
      INIT_S,
      RUN_S
   } pool_state_t;

endpackage

// File: rtl/free_ptr_pool.sv
// Free data-table address pool: self-fills with 0..DEPTH-1 after reset,
// then runs as a show-ahead FIFO of pointers released by the delete engine.
import linked_list_pkg::*;

module free_ptr_pool #(
   parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [A_WIDTH-1:0] add_empty_ptr_i,
   input  logic               add_empty_ptr_en_i,
   output logic [A_WIDTH-1:0] empty_ptr_o,
   output logic               empty_ptr_val_o,
   input  logic               empty_ptr_rd_ack_i,
   output logic               init_done_o,
   output logic [A_WIDTH:0]   free_cnt_o,
   output logic               overflow_o,
   output logic               underflow_o
);

   localparam int               DEPTH = 2**A_WIDTH;
   localparam logic [A_WIDTH:0] FULL  = (A_WIDTH+1)'(DEPTH);
   localparam logic [A_WIDTH-1:0] LAST = '1;

   pool_state_t        state_q, state_d;
   logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [A_WIDTH:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;

   logic               we;
   logic [A_WIDTH-1:0] wdata;
   logic               push;
   logic               pop;

   // Distributed RAM: async read, no reset on contents
   logic [A_WIDTH-1:0] mem [DEPTH];

   assign empty_ptr_o     = mem[rd_ptr_q];
   assign empty_ptr_val_o = (state_q == RUN_S) && (cnt_q != '0);
   assign init_done_o     = (state_q == RUN_S);
   assign free_cnt_o      = cnt_q;
   assign overflow_o      = ovf_q;
   assign underflow_o     = udf_q;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      we         = 1'b0;
      wdata      = add_empty_ptr_i;
      push       = 1'b0;
      pop        = 1'b0;
      unique case (state_q)
         INIT_S: begin
            we         = 1'b1;
            wdata      = init_cnt_q;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            init_cnt_d = init_cnt_q + 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (add_empty_ptr_en_i) ovf_d = 1'b1;
            if (empty_ptr_rd_ack_i) udf_d = 1'b1;
            if (init_cnt_q == LAST) state_d = RUN_S;
         end
         RUN_S: begin
            push = add_empty_ptr_en_i && (cnt_q != FULL);
            pop  = empty_ptr_rd_ack_i && empty_ptr_val_o;
            if (add_empty_ptr_en_i && !push) ovf_d = 1'b1;
            if (empty_ptr_rd_ack_i && !pop)  udf_d = 1'b1;
            we = push;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) cnt_d = cnt_q + 1'b1;
            if (pop && !push) cnt_d = cnt_q - 1'b1;
         end
         default: state_d = INIT_S;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= INIT_S;
         init_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: tb/tb_free_ptr_pool.sv
// Randomized and directed bench for free_ptr_pool against a queue model.
// Model tracks pool contents, fill progress and sticky error flags.
module tb_free_ptr_pool;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] add_ptr = '0;
   logic          add_en = 1'b0;
   logic          ack = 1'b0;
   logic [AW-1:0] ptr_o;
   logic          val_o;
   logic          done_o;
   logic [AW:0]   cnt_o;
   logic          ovf_o;
   logic          udf_o;

   free_ptr_pool #(.A_WIDTH(AW)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .add_empty_ptr_i    (add_ptr),
      .add_empty_ptr_en_i (add_en),
      .empty_ptr_o        (ptr_o),
      .empty_ptr_val_o    (val_o),
      .empty_ptr_rd_ack_i (ack),
      .init_done_o        (done_o),
      .free_cnt_o         (cnt_o),
      .overflow_o         (ovf_o),
      .underflow_o        (udf_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model
   int m_q[$];
   int m_fill;
   bit m_done;
   bit m_ovf;
   bit m_udf;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d @%0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_fill = 0;
      m_done = 0;
      m_ovf  = 0;
      m_udf  = 0;
   endtask

   task automatic model_step(input bit en, input int d, input bit rd);
      int sz;
      sz = m_q.size();
      if (!m_done) begin
         if (en) m_ovf = 1;
         if (rd) m_udf = 1;
         m_q.push_back(m_fill);
         m_fill++;
         if (m_fill == DEPTH) m_done = 1;
      end else begin
         if (en && sz == DEPTH) m_ovf = 1;
         if (rd && sz == 0)     m_udf = 1;
         if (rd && sz != 0)     void'(m_q.pop_front());
         if (en && sz != DEPTH) m_q.push_back(d);
      end
   endtask

   task automatic check_all();
      bit ev;
      ev = m_done && (m_q.size() != 0);
      chk("val", int'(val_o), int'(ev));
      chk("cnt", int'(cnt_o), m_q.size());
      chk("done", int'(done_o), int'(m_done));
      chk("ovf", int'(ovf_o), int'(m_ovf));
      chk("udf", int'(udf_o), int'(m_udf));
      if (ev) chk("head", int'(ptr_o), m_q[0]);
   endtask

   task automatic cyc(input bit en, input int d, input bit rd);
      add_en  = en;
      add_ptr = AW'(d);
      ack     = rd;
      @(posedge clk);
      model_step(en, d, rd);
      #1;
      check_all();
   endtask

   // Asynchronous reset away from the clock edge
   task automatic do_reset();
      add_en = 1'b0;
      ack    = 1'b0;
      rst    = 1'b1;
      #2;
      model_reset();
      chk("rst_cnt", int'(cnt_o), 0);
      chk("rst_val", int'(val_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_ovf", int'(ovf_o), 0);
      chk("rst_udf", int'(udf_o), 0);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #2;
      do_reset();

      // 1: self-fill
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0);
      chk("t1_done", int'(done_o), 1);
      chk("t1_cnt", int'(cnt_o), 16);
      chk("t1_head", int'(ptr_o), 0);

      // 2: pop three
      for (int i = 0; i < 3; i++) cyc(0, 0, 1);
      chk("t2_cnt", int'(cnt_o), 13);
      chk("t2_head", int'(ptr_o), 3);

      // 3: push with pop, 0x9 surfaces after 12 more pops
      cyc(1, 9, 1);
      chk("t3_cnt", int'(cnt_o), 13);
      for (int i = 0; i < 12; i++) cyc(0, 0, 1);
      chk("t3_head", int'(ptr_o), 9);

      // 4: drain, underflow, push into empty
      while (m_q.size() != 0) cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("t4_udf", int'(udf_o), 1);
      chk("t4_val", int'(val_o), 0);
      cyc(1, 5, 0);
      chk("t4_val1", int'(val_o), 1);
      chk("t4_head", int'(ptr_o), 5);

      // 5: overflow when full, then overflow during init
      while (m_q.size() != DEPTH) cyc(1, $urandom_range(15), 0);
      cyc(1, 10, 0);
      chk("t5_ovf", int'(ovf_o), 1);
      chk("t5_cnt", int'(cnt_o), 16);
      do_reset();
      cyc(1, 7, 0);
      chk("t5_iovf", int'(ovf_o), 1);
      for (int i = 1; i < DEPTH; i++) cyc(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t5_fill", int'(ptr_o), i);
         cyc(0, 0, 1);
      end

      // 6: reset mid-run with seven held
      for (int i = 0; i < 7; i++) cyc(1, $urandom_range(15), 0);
      chk("t6_cnt", int'(cnt_o), 7);
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t6_fill", int'(ptr_o), i);
         cyc(0, 0, 1);
      end

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         cyc(bit'($urandom_range(1)), $urandom_range(15),
             bit'($urandom_range(1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
